dmem_hs_ctrl: RTL and testbench

- Parametrised successor to the single-cycle byte-addressed data memory.
- Byte-addressed little-endian data memory behind a valid/ready request/response handshake, with a configurable read latency.
- Loads are sign- or zero-extended in the block; out-of-range and illegal accesses are flagged.
- Sits between the LSU/MEM stage of the pipelined core and on-chip SRAM.

---
 rtl/dmem_pkg.sv | 45 ++++
 rtl/dmem_hs_ctrl_if.sv | 28 ++
 rtl/dmem_hs_ctrl_byte_array.sv | 30 +++
 rtl/dmem_hs_ctrl.sv | 116 +++++++++++
 tb/tb_dmem_hs_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked byte-addressed data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  function automatic logic [3:0] size_bytes(input size_t size);
    return 4'd1 << size;
  endfunction

  function automatic logic [7:0] byte_mask(input size_t size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m;
  endfunction

  // Extends from bit 8*2^size-1; a raw word carries all 8 read lanes.
  function automatic logic [63:0] ld_extend(input logic [63:0] raw, input size_t size,
                                            input logic is_unsigned);
    logic [63:0] r;
    case (size)
      SZ_B:    r = is_unsigned ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      SZ_H:    r = is_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      SZ_W:    r = is_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_hs_ctrl_if.sv
// Request/response bus between the LSU/MEM stage (master) and the data memory (slave).
interface dmem_hs_ctrl_if #(parameter int XLEN = 64) ();

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // the source holds valid and payload stable until then, ready may change freely.
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_hs_ctrl_byte_array.sv
// Byte-wide storage with 8 write lanes and an 8-byte combinational read window at one base address.
module dmem_byte_array #(
  parameter int DEPTH_BYTES = 4096,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic [7:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  // Zero at time 0 only; reset deliberately leaves contents alone.
  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we[i]) mem[addr + AW'(i)] <= wdata[8*i +: 8];
    end
  end

  // Lanes past the top of memory wrap here; the controller never uses them for a legal access.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[addr + AW'(i)];
    end
  end

endmodule

// File: rtl/dmem_hs_ctrl.sv
// Byte-addressed little-endian data memory behind a valid/ready handshake with configurable read latency.
// Build option: define DMEM_MISALIGN_TRAP_EN to flag accesses not aligned to their size as errors.
module dmem_hs_ctrl
  import dmem_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int DEPTH_BYTES = 4096,
  parameter int RD_LATENCY  = 1
) (
  input  logic           clk,
  input  logic           rst,
  dmem_hs_ctrl_if.slave  bus,
  output logic           busy,
  output state_t         state_dbg
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int XW = XLEN + 1;

  state_t          state_q, state_d;
  logic [1:0]      lat_cnt;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  size_t           sz;
  logic [XLEN:0]   last_byte;
  logic            range_err, size_err, mis_err, err;
  logic            accept;
  logic [7:0]      lane_we;
  logic [63:0]     raw;
  logic [63:0]     ld_val;

  assign sz = size_t'(bus.req_size);

  // One extra bit so an access running off the top of the address space cannot wrap back in.
  assign last_byte = {1'b0, bus.req_addr} + XW'(size_bytes(sz)) - XW'(1);
  assign range_err = |last_byte[XLEN:AW];
  assign size_err  = (sz == SZ_D) && ((XLEN == 32) || (!bus.req_we && bus.req_unsigned));

`ifdef DMEM_MISALIGN_TRAP_EN
  logic [2:0] align_mask;
  assign align_mask = 3'(size_bytes(sz) - 4'd1);
  assign mis_err    = |(bus.req_addr[2:0] & align_mask);
`else
  assign mis_err    = 1'b0;
`endif

  assign err     = range_err | size_err | mis_err;
  assign accept  = bus.req_valid && (state_q == IDLE);
  assign lane_we = (accept && bus.req_we && !err) ? byte_mask(sz) : 8'h00;

  dmem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (lane_we),
    .addr  (bus.req_addr[AW-1:0]),
    .wdata (64'(bus.req_wdata)),
    .rdata (raw)
  );

  assign ld_val = ld_extend(raw, sz, bus.req_unsigned);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lat_cnt <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Memory is sampled here so a later store cannot change an in-flight load.
        lat_cnt <= '0;
        err_q   <= err;
        rdata_q <= (err || bus.req_we) ? '0 : XLEN'(ld_val);
      end else if (state_q == WAIT) begin
        lat_cnt <= lat_cnt + 2'd1;
      end else if (state_q == RESP && bus.rsp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (!bus.req_we && !err && RD_LATENCY > 1) state_d = WAIT;
          else                                       state_d = RESP;
        end
      end
      WAIT: begin
        // WAIT spans RD_LATENCY-1 cycles; the accept edge already used one.
        if (lat_cnt == 2'(RD_LATENCY - 2)) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_dmem_hs_ctrl.sv
// Directed bench for dmem_hs_ctrl: one instance at read latency 1, one at read latency 3.
module tb_dmem_hs_ctrl;
  import dmem_pkg::*;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, D = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_hs_ctrl_if #(.XLEN(64)) if1 ();
  dmem_hs_ctrl_if #(.XLEN(64)) if3 ();

  logic        t_we, t_uns, t_rsp_ready, t_valid1, t_valid3;
  logic [1:0]  t_size;
  logic [63:0] t_addr, t_wdata;

  assign if1.req_valid    = t_valid1;
  assign if3.req_valid    = t_valid3;
  assign if1.req_we       = t_we;
  assign if3.req_we       = t_we;
  assign if1.req_size     = t_size;
  assign if3.req_size     = t_size;
  assign if1.req_unsigned = t_uns;
  assign if3.req_unsigned = t_uns;
  assign if1.req_addr     = t_addr;
  assign if3.req_addr     = t_addr;
  assign if1.req_wdata    = t_wdata;
  assign if3.req_wdata    = t_wdata;
  assign if1.rsp_ready    = t_rsp_ready;
  assign if3.rsp_ready    = t_rsp_ready;

  logic   busy1, busy3;
  state_t st1, st3;

  dmem_hs_ctrl #(.XLEN(64), .DEPTH_BYTES(4096), .RD_LATENCY(1)) dut1 (
    .clk (clk), .rst (rst), .bus (if1), .busy (busy1), .state_dbg (st1)
  );

  dmem_hs_ctrl #(.XLEN(64), .DEPTH_BYTES(4096), .RD_LATENCY(3)) dut3 (
    .clk (clk), .rst (rst), .bus (if3), .busy (busy3), .state_dbg (st3)
  );

  // Observation mux: cur selects which instance the checks look at.
  int          cur = 1;
  logic        o_req_ready, o_rsp_valid, o_err, o_busy;
  logic [63:0] o_rdata;
  logic [1:0]  o_state;

  always_comb begin
    if (cur == 3) begin
      o_req_ready = if3.req_ready; o_rsp_valid = if3.rsp_valid; o_rdata = if3.rsp_rdata;
      o_err = if3.rsp_err; o_busy = busy3; o_state = st3;
    end else begin
      o_req_ready = if1.req_ready; o_rsp_valid = if1.rsp_valid; o_rdata = if1.rsp_rdata;
      o_err = if1.rsp_err; o_busy = busy1; o_state = st1;
    end
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction; lat is the expected accept-to-rsp_valid distance, stall the extra
  // cycles rsp_ready is held low while a bogus store is presented (must be ignored).
  task automatic do_req(input int sel, input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_rdata, input logic exp_err,
                        input int lat, input int stall, input string tag);
    cur = sel;
    @(negedge clk);
    chk({tag, "/req_ready_idle"}, 64'(o_req_ready), 64'd1);
    t_we = we; t_size = size; t_uns = uns; t_addr = addr; t_wdata = wdata;
    t_rsp_ready = (stall == 0);
    if (sel == 3) t_valid3 = 1'b1; else t_valid1 = 1'b1;
    @(posedge clk);
    #1;
    t_valid1 = 1'b0; t_valid3 = 1'b0;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      chk({tag, "/wait_valid"}, 64'(o_rsp_valid), 64'd0);
      chk({tag, "/wait_req_ready"}, 64'(o_req_ready), 64'd0);
      chk({tag, "/wait_busy"}, 64'(o_busy), 64'd1);
    end
    @(negedge clk);
    chk({tag, "/rsp_valid"}, 64'(o_rsp_valid), 64'd1);
    chk({tag, "/rdata"}, o_rdata, exp_rdata);
    chk({tag, "/err"}, 64'(o_err), 64'(exp_err));
    for (int s = 0; s < stall; s++) begin
      t_we = 1'b1; t_size = D; t_addr = 64'h10; t_wdata = 64'h0;
      if (sel == 3) t_valid3 = 1'b1; else t_valid1 = 1'b1;
      @(negedge clk);
      chk({tag, "/hold_valid"}, 64'(o_rsp_valid), 64'd1);
      chk({tag, "/hold_rdata"}, o_rdata, exp_rdata);
      chk({tag, "/hold_req_ready"}, 64'(o_req_ready), 64'd0);
    end
    t_valid1 = 1'b0; t_valid3 = 1'b0;
    t_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "/post_valid"}, 64'(o_rsp_valid), 64'd0);
    chk({tag, "/post_busy"}, 64'(o_busy), 64'd0);
  endtask

  logic [64:0] exp_mis;

  initial begin
    t_we = 1'b0; t_uns = 1'b0; t_size = B; t_addr = '0; t_wdata = '0;
    t_valid1 = 1'b0; t_valid3 = 1'b0; t_rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 1; s <= 3; s += 2) begin
      cur = s;
      #0;
      chk("reset/req_ready", 64'(o_req_ready), 64'd1);
      chk("reset/rsp_valid", 64'(o_rsp_valid), 64'd0);
      chk("reset/rdata", o_rdata, 64'd0);
      chk("reset/err", 64'(o_err), 64'd0);
      chk("reset/busy", 64'(o_busy), 64'd0);
    end

    // Latency-1 instance: store/load, extension, range limits.
    do_req(1, 1, D, 0, 64'h10, 64'h8000_0000_0000_00FF, 64'h0, 0, 1, 0, "sd_10");
    do_req(1, 0, D, 0, 64'h10, 64'h0, 64'h8000_0000_0000_00FF, 0, 1, 0, "ld_10");
    do_req(1, 1, B, 0, 64'h20, 64'h1234_5680, 64'h0, 0, 1, 0, "sb_20");
    do_req(1, 1, B, 1, 64'h21, 64'h5A, 64'h0, 0, 1, 0, "sb_21");
    do_req(1, 0, B, 0, 64'h20, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0, 1, 0, "lb_20");
    do_req(1, 0, B, 1, 64'h20, 64'h0, 64'h0000_0000_0000_0080, 0, 1, 0, "lbu_20");
    do_req(1, 1, H, 0, 64'h22, 64'hAAAA_8001, 64'h0, 0, 1, 0, "sh_22");
    do_req(1, 0, H, 1, 64'h22, 64'h0, 64'h0000_0000_0000_8001, 0, 1, 0, "lhu_22");
    do_req(1, 0, H, 0, 64'h22, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 0, 1, 0, "lh_22");
    do_req(1, 1, B, 0, 64'h24, 64'hC3, 64'h0, 0, 1, 0, "sb_24");
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_mis = {1'b1, 64'h0};
`else
    exp_mis = {1'b0, 64'hFFFF_FFFF_C380_015A};
`endif
    do_req(1, 0, W, 0, 64'h21, 64'h0, exp_mis[63:0], exp_mis[64], 1, 0, "lw_21_mis");
    do_req(1, 0, W, 0, 64'hFFE, 64'h0, 64'h0, 1, 1, 0, "lw_ffe_oor");
    do_req(1, 1, W, 0, 64'hFFC, 64'hDEAD_BEEF, 64'h0, 0, 1, 0, "sw_ffc");
    do_req(1, 0, W, 0, 64'hFFC, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 0, 1, 0, "lw_ffc");
    do_req(1, 0, W, 1, 64'hFFC, 64'h0, 64'h0000_0000_DEAD_BEEF, 0, 1, 0, "lwu_ffc");
    do_req(1, 1, D, 0, 64'hFF9, 64'h1111_1111_1111_1111, 64'h0, 1, 1, 0, "sd_ff9_oor");
    do_req(1, 0, W, 0, 64'hFFC, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 0, 1, 0, "lw_ffc_kept");
    do_req(1, 0, B, 0, 64'hFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFDE, 0, 1, 0, "lb_fff_edge");
    do_req(1, 0, B, 0, 64'h1000, 64'h0, 64'h0, 1, 1, 0, "lb_1000_oor");
    do_req(1, 0, B, 0, 64'h1_0000_0010, 64'h0, 64'h0, 1, 1, 0, "lb_hiaddr");
    do_req(1, 0, D, 1, 64'h10, 64'h0, 64'h0, 1, 1, 0, "ldu_illegal");

    // Latency-3 instance: backpressure, ignored requests, reset in WAIT.
    do_req(3, 1, D, 0, 64'h10, 64'h8000_0000_0000_00FF, 64'h0, 0, 1, 0, "l3_sd_10");
    do_req(3, 0, D, 0, 64'h10, 64'h0, 64'h8000_0000_0000_00FF, 0, 3, 5, "l3_ld_bp");

    cur = 3;
    @(negedge clk);
    t_we = 1'b0; t_size = B; t_uns = 1'b0; t_addr = 64'h10; t_rsp_ready = 1'b1;
    t_valid3 = 1'b1;
    @(posedge clk);
    #1;
    t_valid3 = 1'b0;
    @(negedge clk);
    chk("rst_wait/state", 64'(o_state), 64'(WAIT));
    chk("rst_wait/busy_before", 64'(o_busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_wait/rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("rst_wait/req_ready", 64'(o_req_ready), 64'd1);
    chk("rst_wait/busy", 64'(o_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wait/no_rsp", 64'(o_rsp_valid), 64'd0);
    do_req(3, 0, D, 0, 64'h10, 64'h0, 64'h8000_0000_0000_00FF, 0, 3, 0, "l3_ld_after_rst");
    do_req(1, 0, W, 0, 64'hFFC, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 0, 1, 0, "l1_ld_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
